// File: rtl/rank_encoder_mc.sv
// rtl/rank_encoder_mc.sv - rank-order spike encoder with 4-phase AER output
//
// Buffers one streamed image. It then replays the pixel addresses as AER
// events in descending intensity order, with ties going to the lower address
// first. An optional sync event (address IMAGE_SIZE) follows each intensity level.
//
// Ports
//   CLK             clock, rising edge
//   RST             synchronous active-low reset
//   NEW_IMAGE       start pulse, honoured only in IDLE
//   PIXEL_IN        streamed pixel, address order 0..IMAGE_SIZE-1
//   PIXEL_VALID     PIXEL_IN valid
//   PIXEL_READY     pixel accepted when PIXEL_VALID && PIXEL_READY
//   MODE            0 = rank order, 1 = rank order plus per-level sync event
//   THRESHOLD       minimum intensity emitted
//   MAX_SPIKES      cap on pixel events, 0 = unlimited
//   INFERENCE_DONE  releases DONE or aborts encoding
//   IMAGE_ENCODED   high while in DONE
//   SPIKE_COUNT     pixel events completed for this image
//   AERIN_ADDR      event address
//   AERIN_REQ       4-phase request
//   AERIN_ACK       4-phase acknowledge
module rank_encoder_mc #(
    parameter int IMAGE_SIZE = 784,
    parameter int PIXEL_BITS = 8,
    parameter int ADDR_BITS  = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  NEW_IMAGE,
    input  logic [PIXEL_BITS-1:0] PIXEL_IN,
    input  logic                  PIXEL_VALID,
    output logic                  PIXEL_READY,
    input  logic                  MODE,
    input  logic [PIXEL_BITS-1:0] THRESHOLD,
    input  logic [ADDR_BITS-1:0]  MAX_SPIKES,
    input  logic                  INFERENCE_DONE,
    output logic                  IMAGE_ENCODED,
    output logic [ADDR_BITS-1:0]  SPIKE_COUNT,
    output logic [ADDR_BITS-1:0]  AERIN_ADDR,
    output logic                  AERIN_REQ,
    input  logic                  AERIN_ACK
);

    localparam int IDX_BITS = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(IMAGE_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] SYNC_ADDR = ADDR_BITS'(IMAGE_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_REQ,
        S_ACKLO,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [PIXEL_BITS-1:0] pix_mem [IMAGE_SIZE];

    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [PIXEL_BITS-1:0] level_q, level_d;
    logic [PIXEL_BITS-1:0] next_q, next_d;
    logic                  found_q, found_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  sync_q, sync_d;
    logic                  abort_q, abort_d;
    logic [ADDR_BITS-1:0]  count_q, count_d;
    logic                  mode_q, mode_d;
    logic [PIXEL_BITS-1:0] thr_q, thr_d;
    logic [ADDR_BITS-1:0]  max_q, max_d;

    logic [PIXEL_BITS-1:0] cur_pix;
    logic                  scan_lower;
    logic [PIXEL_BITS-1:0] merged_next;
    logic [PIXEL_BITS-1:0] load_level;
    logic [ADDR_BITS-1:0]  count_inc;
    logic                  wr_en;

    // End-of-pass request raised by SCAN or ACKLO, resolved after the case.
    logic                  do_eop;
    logic [PIXEL_BITS-1:0] eop_next;
    logic                  eop_found;
    logic                  eop_sync;

    assign cur_pix     = pix_mem[idx_q[IDX_BITS-1:0]];
    assign scan_lower  = (cur_pix < level_q);
    assign merged_next = (scan_lower && (cur_pix > next_q)) ? cur_pix : next_q;
    assign load_level  = (PIXEL_IN > level_q) ? PIXEL_IN : level_q;
    assign count_inc   = (count_q == SYNC_ADDR) ? count_q : count_q + ADDR_BITS'(1);
    assign wr_en       = RST && (state_q == S_LOAD) && PIXEL_VALID;

    assign PIXEL_READY   = (state_q == S_LOAD);
    assign IMAGE_ENCODED = (state_q == S_DONE);
    assign AERIN_REQ     = (state_q == S_REQ);
    assign AERIN_ADDR    = addr_q;
    assign SPIKE_COUNT   = count_q;

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pix_mem[idx_q[IDX_BITS-1:0]] <= PIXEL_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            level_q <= '0;
            next_q  <= '0;
            found_q <= 1'b0;
            addr_q  <= '0;
            sync_q  <= 1'b0;
            abort_q <= 1'b0;
            count_q <= '0;
            mode_q  <= 1'b0;
            thr_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            next_q  <= next_d;
            found_q <= found_d;
            addr_q  <= addr_d;
            sync_q  <= sync_d;
            abort_q <= abort_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
            max_q   <= max_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        level_d   = level_q;
        next_d    = next_q;
        found_d   = found_q;
        addr_d    = addr_q;
        sync_d    = sync_q;
        abort_d   = abort_q;
        count_d   = count_q;
        mode_d    = mode_q;
        thr_d     = thr_q;
        max_d     = max_q;
        do_eop    = 1'b0;
        eop_next  = '0;
        eop_found = 1'b0;
        eop_sync  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (NEW_IMAGE) begin
                    mode_d  = MODE;
                    thr_d   = THRESHOLD;
                    max_d   = MAX_SPIKES;
                    count_d = '0;
                    idx_d   = '0;
                    level_d = '0;
                    next_d  = '0;
                    found_d = 1'b0;
                    abort_d = 1'b0;
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (INFERENCE_DONE) begin
                    state_d = S_IDLE;
                end else if (PIXEL_VALID) begin
                    level_d = load_level;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        // Brightest pixel already below threshold: nothing to emit.
                        state_d = (load_level < thr_q) ? S_DONE : S_SCAN;
                    end else begin
                        idx_d = idx_q + ADDR_BITS'(1);
                    end
                end
            end

            S_SCAN: begin
                if (INFERENCE_DONE) begin
                    state_d = S_IDLE;
                end else if (cur_pix == level_q) begin
                    addr_d  = idx_q;
                    sync_d  = 1'b0;
                    state_d = S_REQ;
                end else begin
                    next_d  = merged_next;
                    found_d = found_q | scan_lower;
                    if (idx_q == LAST_IDX) begin
                        // Last pixel decided in the same cycle so a pass
                        // without matches costs exactly IMAGE_SIZE cycles.
                        do_eop    = 1'b1;
                        eop_next  = merged_next;
                        eop_found = found_q | scan_lower;
                        eop_sync  = 1'b1;
                    end else begin
                        idx_d = idx_q + ADDR_BITS'(1);
                    end
                end
            end

            S_REQ: begin
                if (INFERENCE_DONE) begin
                    abort_d = 1'b1;
                end
                if (AERIN_ACK) begin
                    state_d = S_ACKLO;
                end
            end

            S_ACKLO: begin
                if (INFERENCE_DONE) begin
                    abort_d = 1'b1;
                end
                if (!AERIN_ACK) begin
                    if (abort_q || INFERENCE_DONE) begin
                        abort_d = 1'b0;
                        state_d = S_IDLE;
                    end else if (sync_q) begin
                        // Sync already sent for this pass; only the level step remains.
                        do_eop    = 1'b1;
                        eop_next  = next_q;
                        eop_found = found_q;
                        eop_sync  = 1'b0;
                    end else begin
                        count_d = count_inc;
                        if ((max_q != '0) && (count_inc == max_q)) begin
                            state_d = S_DONE;
                        end else if (idx_q == LAST_IDX) begin
                            do_eop    = 1'b1;
                            eop_next  = next_q;
                            eop_found = found_q;
                            eop_sync  = 1'b1;
                        end else begin
                            idx_d   = idx_q + ADDR_BITS'(1);
                            state_d = S_SCAN;
                        end
                    end
                end
            end

            S_DONE: begin
                if (INFERENCE_DONE) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (do_eop) begin
            if (eop_sync && mode_q) begin
                // Keep the pass results; they are consumed after the sync handshake.
                next_d  = eop_next;
                found_d = eop_found;
                addr_d  = SYNC_ADDR;
                sync_d  = 1'b1;
                state_d = S_REQ;
            end else if (!eop_found || (eop_next < thr_q)) begin
                state_d = S_DONE;
            end else begin
                level_d = eop_next;
                next_d  = '0;
                found_d = 1'b0;
                idx_d   = '0;
                state_d = S_SCAN;
            end
        end
    end

endmodule

// File: tb/tb_rank_encoder_mc.sv
// tb/tb_rank_encoder_mc.sv - directed self-checking bench for rank_encoder_mc
module tb_rank_encoder_mc;

    localparam int N  = 4;
    localparam int PB = 8;
    localparam int AB = 3;

    logic          CLK;
    logic          RST;
    logic          NEW_IMAGE;
    logic [PB-1:0] PIXEL_IN;
    logic          PIXEL_VALID;
    logic          PIXEL_READY;
    logic          MODE;
    logic [PB-1:0] THRESHOLD;
    logic [AB-1:0] MAX_SPIKES;
    logic          INFERENCE_DONE;
    logic          IMAGE_ENCODED;
    logic [AB-1:0] SPIKE_COUNT;
    logic [AB-1:0] AERIN_ADDR;
    logic          AERIN_REQ;
    logic          AERIN_ACK;

    int      checks;
    int      failures;
    int      ev[$];
    bit      resp_en;
    int      ack_dly;
    logic [PB-1:0] img [N];
    int      exp_arr [8];
    int      exp_n;
    int      n;

    rank_encoder_mc #(
        .IMAGE_SIZE(N),
        .PIXEL_BITS(PB),
        .ADDR_BITS (AB)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .NEW_IMAGE     (NEW_IMAGE),
        .PIXEL_IN      (PIXEL_IN),
        .PIXEL_VALID   (PIXEL_VALID),
        .PIXEL_READY   (PIXEL_READY),
        .MODE          (MODE),
        .THRESHOLD     (THRESHOLD),
        .MAX_SPIKES    (MAX_SPIKES),
        .INFERENCE_DONE(INFERENCE_DONE),
        .IMAGE_ENCODED (IMAGE_ENCODED),
        .SPIKE_COUNT   (SPIKE_COUNT),
        .AERIN_ADDR    (AERIN_ADDR),
        .AERIN_REQ     (AERIN_REQ),
        .AERIN_ACK     (AERIN_ACK)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // AER receiver: records each address and answers with ack_dly cycles of latency.
    initial begin
        AERIN_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (resp_en && AERIN_REQ && !AERIN_ACK) begin
                ev.push_back(int'(AERIN_ADDR));
                repeat (ack_dly) @(negedge CLK);
                AERIN_ACK = 1'b1;
            end else if (AERIN_ACK && !AERIN_REQ) begin
                repeat (ack_dly) @(negedge CLK);
                AERIN_ACK = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic start_load(input logic m, input logic [PB-1:0] thr, input logic [AB-1:0] mx);
        @(negedge CLK);
        MODE       = m;
        THRESHOLD  = thr;
        MAX_SPIKES = mx;
        NEW_IMAGE  = 1'b1;
        @(negedge CLK);
        NEW_IMAGE  = 1'b0;
        // Post-latch changes must have no effect.
        MODE       = ~m;
        THRESHOLD  = 8'hFF;
        MAX_SPIKES = 3'd1;
        for (int i = 0; i < N; i++) begin
            if (i == 0) check("ready_in_load", PIXEL_READY, 1);
            PIXEL_IN    = img[i];
            PIXEL_VALID = 1'b1;
            @(negedge CLK);
        end
        PIXEL_VALID = 1'b0;
    endtask

    task automatic wait_enc(input string tag);
        int k;
        k = 0;
        while (IMAGE_ENCODED !== 1'b1 && k < 300) begin
            @(negedge CLK);
            k++;
        end
        check(tag, IMAGE_ENCODED, 1);
    endtask

    task automatic release_done(input string tag);
        @(negedge CLK);
        INFERENCE_DONE = 1'b1;
        @(negedge CLK);
        INFERENCE_DONE = 1'b0;
        check(tag, IMAGE_ENCODED, 0);
    endtask

    task automatic check_events(input string tag);
        check({tag, "_nev"}, ev.size(), exp_n);
        for (int i = 0; i < exp_n && i < ev.size(); i++) begin
            check($sformatf("%s_ev%0d", tag, i), ev[i], exp_arr[i]);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        resp_en        = 1'b1;
        ack_dly        = 1;
        RST            = 1'b0;
        NEW_IMAGE      = 1'b0;
        PIXEL_IN       = '0;
        PIXEL_VALID    = 1'b0;
        MODE           = 1'b0;
        THRESHOLD      = '0;
        MAX_SPIKES     = '0;
        INFERENCE_DONE = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst_ready", PIXEL_READY, 0);
        check("rst_req", AERIN_REQ, 0);
        check("rst_addr", AERIN_ADDR, 0);
        check("rst_enc", IMAGE_ENCODED, 0);
        check("rst_count", SPIKE_COUNT, 0);
        RST = 1'b1;

        // Plain rank order.
        img = '{8'd3, 8'd7, 8'd7, 8'd1};
        ev.delete();
        start_load(1'b0, 8'd0, 3'd0);
        wait_enc("A_done");
        exp_arr = '{1, 2, 0, 3, 0, 0, 0, 0};
        exp_n   = 4;
        check_events("A");
        check("A_count", SPIKE_COUNT, 4);
        release_done("A_clear");

        // Sync mode.
        ev.delete();
        start_load(1'b1, 8'd0, 3'd0);
        wait_enc("B_done");
        exp_arr = '{1, 2, 4, 0, 4, 3, 4, 0};
        exp_n   = 7;
        check_events("B");
        check("B_count", SPIKE_COUNT, 4);
        release_done("B_clear");

        // Threshold cuts lower levels.
        ev.delete();
        start_load(1'b0, 8'd4, 3'd0);
        wait_enc("C_done");
        exp_arr = '{1, 2, 0, 0, 0, 0, 0, 0};
        exp_n   = 2;
        check_events("C");
        check("C_count", SPIKE_COUNT, 2);
        release_done("C_clear");

        // All-zero image under threshold: DONE one cycle after load.
        img = '{8'd0, 8'd0, 8'd0, 8'd0};
        ev.delete();
        start_load(1'b0, 8'd1, 3'd0);
        check("D_enc_now", IMAGE_ENCODED, 1);
        check("D_nev", ev.size(), 0);
        check("D_count", SPIKE_COUNT, 0);
        release_done("D_clear");

        // Spike cap.
        img = '{8'd3, 8'd7, 8'd7, 8'd1};
        ev.delete();
        start_load(1'b0, 8'd0, 3'd2);
        wait_enc("E_done");
        exp_arr = '{1, 2, 0, 0, 0, 0, 0, 0};
        exp_n   = 2;
        check_events("E");
        check("E_count", SPIKE_COUNT, 2);
        repeat (10) @(negedge CLK);
        check("E_req_low", AERIN_REQ, 0);
        check("E_nev_after", ev.size(), 2);
        check("E_enc_hold", IMAGE_ENCODED, 1);
        release_done("E_clear");

        // Abort during a slow handshake on the second event.
        ack_dly = 5;
        ev.delete();
        start_load(1'b0, 8'd0, 3'd0);
        n = 0;
        while (!(AERIN_REQ === 1'b1 && SPIKE_COUNT === 3'd1) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("F_second_req", (AERIN_REQ === 1'b1 && SPIKE_COUNT === 3'd1), 1);
        INFERENCE_DONE = 1'b1;
        @(negedge CLK);
        INFERENCE_DONE = 1'b0;
        check("F_req_held", AERIN_REQ, 1);
        n = 0;
        while (AERIN_ACK !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("F_ack_rose", AERIN_ACK, 1);
        n = 0;
        while (AERIN_ACK !== 1'b0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("F_ack_fell", AERIN_ACK, 0);
        repeat (2) @(negedge CLK);
        check("F_req", AERIN_REQ, 0);
        check("F_ready", PIXEL_READY, 0);
        check("F_enc", IMAGE_ENCODED, 0);
        check("F_count", SPIKE_COUNT, 1);
        repeat (5) @(negedge CLK);
        check("F_nev", ev.size(), 2);
        check("F_req_idle", AERIN_REQ, 0);

        ack_dly = 1;
        ev.delete();
        start_load(1'b0, 8'd0, 3'd0);
        wait_enc("F2_done");
        exp_arr = '{1, 2, 0, 3, 0, 0, 0, 0};
        exp_n   = 4;
        check_events("F2");
        check("F2_count", SPIKE_COUNT, 4);
        release_done("F2_clear");

        // Reset while REQ is high and ACK is held low.
        resp_en = 1'b0;
        ev.delete();
        start_load(1'b0, 8'd0, 3'd0);
        n = 0;
        while (AERIN_REQ !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("G_req_seen", AERIN_REQ, 1);
        check("G_addr", AERIN_ADDR, 1);
        RST = 1'b0;
        @(negedge CLK);
        check("G_rst_req", AERIN_REQ, 0);
        check("G_rst_addr", AERIN_ADDR, 0);
        check("G_rst_count", SPIKE_COUNT, 0);
        check("G_rst_enc", IMAGE_ENCODED, 0);
        check("G_rst_ready", PIXEL_READY, 0);
        RST = 1'b1;

        // Reset in the middle of a load.
        @(negedge CLK);
        NEW_IMAGE = 1'b1;
        @(negedge CLK);
        NEW_IMAGE   = 1'b0;
        PIXEL_IN    = 8'd9;
        PIXEL_VALID = 1'b1;
        @(negedge CLK);
        check("H_ready_load", PIXEL_READY, 1);
        RST = 1'b0;
        @(negedge CLK);
        check("H_rst_ready", PIXEL_READY, 0);
        RST         = 1'b1;
        PIXEL_VALID = 1'b0;
        @(negedge CLK);
        check("H_idle_ready", PIXEL_READY, 0);

        // A pixel pulse during SCAN must not be taken.
        ev.delete();
        img = '{8'd3, 8'd7, 8'd7, 8'd1};
        start_load(1'b0, 8'd0, 3'd0);
        check("I_ready_scan", PIXEL_READY, 0);
        PIXEL_IN    = 8'hFF;
        PIXEL_VALID = 1'b1;
        @(negedge CLK);
        PIXEL_VALID = 1'b0;
        check("I_ready_scan2", PIXEL_READY, 0);
        resp_en = 1'b1;
        wait_enc("I_done");
        exp_arr = '{1, 2, 0, 3, 0, 0, 0, 0};
        exp_n   = 4;
        check_events("I");
        check("I_count", SPIKE_COUNT, 4);
        release_done("I_clear");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
